// File: rtl/colorsched_pkg.sv
// Shared types and constants for the ColorCalc frame scheduler.
package colorsched_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} sched_state_t;

    typedef logic [23:0] rgb_t;

    localparam int CC_LAT_DEFAULT = 3;

    // Note-index width that stays legal for a single-note frame.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/color_frame_buffer.sv
// Per-note colour buffer: N rgb_t entries, one registered read port.
// Write port 1 exists only when COLORSCHED_SKIP_ZERO_EN is defined.
module color_frame_buffer
    import colorsched_pkg::*;
#(
    parameter int  N     = 12,
    localparam int IDX_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we0,
    input  logic [IDX_W-1:0] waddr0,
    input  rgb_t             wdata0,
`ifdef COLORSCHED_SKIP_ZERO_EN
    input  logic             we1,
    input  logic [IDX_W-1:0] waddr1,
    input  rgb_t             wdata1,
`endif
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output rgb_t             rdata
);

    rgb_t mem [N];
    rgb_t rd_val;

    // Forward a same-cycle write so a read never returns the pre-write entry.
    always_comb begin
        rd_val = mem[raddr];
        if (we0 && (waddr0 == raddr)) begin
            rd_val = wdata0;
        end
`ifdef COLORSCHED_SKIP_ZERO_EN
        if (we1 && (waddr1 == raddr)) begin
            rd_val = wdata1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we0) begin
                mem[waddr0] <= wdata0;
            end
`ifdef COLORSCHED_SKIP_ZERO_EN
            if (we1) begin
                mem[waddr1] <= wdata1;
            end
`endif
            if (re) begin
                rdata <= rd_val;
            end
        end
    end

endmodule

// File: rtl/color_calc_scheduler.sv
// Time-shares one ColorCalc pipeline across N notes per frame and streams the results out.
// COLORSCHED_SKIP_ZERO_EN: zero fast-amplitude notes bypass ColorCalc and write black directly.
module color_calc_scheduler
    import colorsched_pkg::*;
#(
    parameter int  W      = 5,
    parameter int  D      = 11,
    parameter int  N      = 12,
    parameter int  CC_LAT = CC_LAT_DEFAULT,
    localparam int AW     = W + D,
    localparam int HW     = D - 1,
    localparam int IDX_W  = idx_width(N),
    localparam int CW     = $clog2(CC_LAT + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [N*AW-1:0]  noteAmplitude_i,
    input  logic [N*AW-1:0]  noteAmplitudeFast_i,
    input  logic [N*HW-1:0]  noteHue_i,
    output logic [AW-1:0]    cc_amp_o,
    output logic [AW-1:0]    cc_ampFast_o,
    output logic [HW-1:0]    cc_hue_o,
    output logic             cc_start_o,
    input  rgb_t             cc_rgb_i,
    input  logic             cc_data_v_i,
    output rgb_t             led_rgb_o,
    output logic [IDX_W-1:0] led_idx_o,
    output logic             led_valid_o,
    output logic             led_last_o,
    input  logic             led_ready_i,
    output logic             busy_o,
    output logic             frame_drop_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    sched_state_t     state, state_nxt;
    logic [N*AW-1:0]  snap_amp, snap_fast;
    logic [N*HW-1:0]  snap_hue;
    logic [IDX_W-1:0] issue_idx, issue_k, cc_idx, rd_addr;
    logic [IDX_W-1:0] idx_pipe [CC_LAT];
    logic [CW-1:0]    inflight, inflight_nxt;
    logic [AW-1:0]    src_amp, src_fast;
    logic [HW-1:0]    src_hue;
    logic             issue_now, start_nxt, ret_we, out_hs, load_out;

    // Note 0 is taken straight from the inputs so it issues in the cycle after frame_start.
    always_comb begin
        state_nxt = state;
        issue_now = 1'b0;
        issue_k   = issue_idx;
        if (state == ISSUE) begin
            src_amp  = snap_amp[int'(issue_idx)*AW +: AW];
            src_fast = snap_fast[int'(issue_idx)*AW +: AW];
            src_hue  = snap_hue[int'(issue_idx)*HW +: HW];
        end else begin
            src_amp  = noteAmplitude_i[AW-1:0];
            src_fast = noteAmplitudeFast_i[AW-1:0];
            src_hue  = noteHue_i[HW-1:0];
        end

        ret_we       = cc_data_v_i && (inflight != '0);
        inflight_nxt = inflight;
        if (cc_start_o && !ret_we) begin
            inflight_nxt = inflight + CW'(1);
        end else if (!cc_start_o && ret_we) begin
            inflight_nxt = inflight - CW'(1);
        end

        out_hs   = led_valid_o && led_ready_i;
        load_out = 1'b0;
        rd_addr  = led_idx_o + IDX_W'(1);

        case (state)
            IDLE: begin
                if (frame_start) begin
                    issue_now = 1'b1;
                    issue_k   = '0;
                    state_nxt = (N == 1) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                issue_now = 1'b1;
                if (issue_idx == LAST_IDX) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight_nxt == '0) begin
                    state_nxt = OUTPUT;
                    load_out  = 1'b1;
                    rd_addr   = '0;
                end
            end
            OUTPUT: begin
                if (out_hs) begin
                    if (led_idx_o == LAST_IDX) begin
                        state_nxt = IDLE;
                    end else begin
                        load_out = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef COLORSCHED_SKIP_ZERO_EN
    logic skip_we;
    assign start_nxt = issue_now && (src_fast != '0);
    assign skip_we   = issue_now && (src_fast == '0);
`else
    assign start_nxt = issue_now;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if ((state == IDLE) && frame_start) begin
            snap_amp  <= noteAmplitude_i;
            snap_fast <= noteAmplitudeFast_i;
            snap_hue  <= noteHue_i;
        end
    end

    // Issue registers, index pipeline, in-flight count and the LED-side handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_start_o   <= 1'b0;
            cc_amp_o     <= '0;
            cc_ampFast_o <= '0;
            cc_hue_o     <= '0;
            cc_idx       <= '0;
            issue_idx    <= '0;
            inflight     <= '0;
            for (int i = 0; i < CC_LAT; i++) begin
                idx_pipe[i] <= '0;
            end
            led_valid_o  <= 1'b0;
            led_last_o   <= 1'b0;
            led_idx_o    <= '0;
            busy_o       <= 1'b0;
            frame_drop_o <= 1'b0;
        end else begin
            cc_start_o <= start_nxt;
            if (issue_now) begin
                cc_amp_o     <= src_amp;
                cc_ampFast_o <= src_fast;
                cc_hue_o     <= src_hue;
                cc_idx       <= issue_k;
                issue_idx    <= issue_k + IDX_W'(1);
            end
            inflight    <= inflight_nxt;
            idx_pipe[0] <= cc_start_o ? cc_idx : '0;
            for (int i = 1; i < CC_LAT; i++) begin
                idx_pipe[i] <= idx_pipe[i-1];
            end
            busy_o       <= (state_nxt != IDLE);
            frame_drop_o <= frame_start && (state != IDLE);
            if (load_out) begin
                led_valid_o <= 1'b1;
                led_idx_o   <= rd_addr;
                led_last_o  <= (rd_addr == LAST_IDX);
            end else if (out_hs) begin
                led_valid_o <= 1'b0;
                led_last_o  <= 1'b0;
            end
        end
    end

    color_frame_buffer #(.N(N)) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we0    (ret_we),
        .waddr0 (idx_pipe[CC_LAT-1]),
        .wdata0 (cc_rgb_i),
`ifdef COLORSCHED_SKIP_ZERO_EN
        .we1    (skip_we),
        .waddr1 (issue_k),
        .wdata1 (24'h0),
`endif
        .re     (load_out),
        .raddr  (rd_addr),
        .rdata  (led_rgb_o)
    );

endmodule

// File: doc/color_calc_scheduler.md
# color_calc_scheduler

Frame-level controller that time-shares one ColorCalc pipeline across all N notes from the LinearVisualizer. Each frame it latches N note records, issues them into ColorCalc one per cycle, writes each returning RGB word into a per-note colour buffer by index, and then streams the buffer to the LED output stage over a valid/ready handshake. It sits between LinearVisualizer and the LED driver and owns ColorCalc's `start` input.

## Interface
- `W`, 5: whole bits of the note fixed-point format.
- `D`, 11: decimal bits of the note fixed-point format. Must match ColorCalc.
- `N`, 12: notes per frame. Range 1..64.
- `CC_LAT`, 3: ColorCalc latency, in cycles from `start` to `data_v`.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse; note arrays are valid in this cycle.
- `noteAmplitude_i` in N×(W+D): reduced/filtered amplitudes, packed with note 0 in the LSBs.
- `noteAmplitudeFast_i` in N×(W+D): fast amplitudes.
- `noteHue_i` in N×(D-1): hues, 0..1023.
- `cc_amp_o` out W+D: to ColorCalc `noteAmplitude_i`.
- `cc_ampFast_o` out W+D: to ColorCalc `noteAmplitudeFast_i`.
- `cc_hue_o` out D-1: to ColorCalc `noteHue_i`.
- `cc_start_o` out 1: to ColorCalc `start`.
- `cc_rgb_i` in 24: from ColorCalc `rgb`.
- `cc_data_v_i` in 1: from ColorCalc `data_v`.
- `led_rgb_o` out 24: colour for the LED stage.
- `led_idx_o` out $clog2(N): note index of `led_rgb_o`.
- `led_valid_o` out 1: output word is valid.
- `led_last_o` out 1: asserted with the word at index N-1.
- `led_ready_i` in 1: LED stage accepts the word.
- `busy_o` out 1: high in every state except IDLE.
- `frame_drop_o` out 1: one-cycle pulse when a `frame_start` is rejected.

## Operation
- State machine states: IDLE, ISSUE, DRAIN, OUTPUT.
- IDLE:
  - On `frame_start`, latch all three note arrays into a local snapshot.
  - Clear the issue index and the in-flight counter.
  - Go to ISSUE.
- ISSUE:
  - Each cycle, drive snapshot note k on the `cc_*` outputs with `cc_start_o`=1, then k++.
  - After issuing k=N-1, go to DRAIN.
- Index pipeline:
  - The issued index enters a CC_LAT-deep shift register that is qualified by `cc_start_o`.
  - When `cc_data_v_i`=1, write `cc_rgb_i` to buffer[index at the head of the pipeline].
  - Results return in issue order.
- In-flight counter:
  - Increments on `cc_start_o` and decrements on `cc_data_v_i`.
  - When both occur in the same cycle, the counter holds.
  - Width is $clog2(CC_LAT+2).
- DRAIN: go to OUTPUT when the in-flight counter is 0 and no `cc_data_v_i` is pending this cycle.
- OUTPUT:
  - Read index r starts at 0.
  - `led_valid_o`=1, `led_rgb_o`=buffer[r], `led_idx_o`=r.
  - On `led_valid_o & led_ready_i`, r++.
  - The handshake at r=N-1 returns the block to IDLE.
  - Output data holds stable while `led_ready_i`=0.
- `frame_start` in any state other than IDLE:
  - The frame is ignored, `frame_drop_o` pulses, and the snapshot is unchanged.
- `cc_data_v_i` asserted when the in-flight counter is 0 is a protocol error. The write is discarded and the counter stays at 0 (no underflow).
- Buffer contents persist across frames. Every entry is overwritten before each OUTPUT.

## Timing
- Cycle 0: `frame_start` is sampled.
- Cycles 1..N: `cc_start_o`=1.
- Cycle N+CC_LAT: the last `cc_data_v_i` arrives.
- Cycle N+CC_LAT+1: first `led_valid_o`.
- Minimum frame period is N+CC_LAT+1+N cycles when `led_ready_i` is held at 1.
- All outputs are registered; there is no combinational path from `led_ready_i` to `led_valid_o`.
- Reset values:
  - State IDLE.
  - `cc_start_o`, `led_valid_o`, `led_last_o`, `busy_o`, `frame_drop_o` = 0.
  - `cc_*` data, `led_rgb_o`, `led_idx_o` = 0.
  - Counters and buffer = 0.
- `rst_n` asserted mid-frame:
  - Immediate return to IDLE with all outputs at reset values.
  - Results still in flight inside ColorCalc are discarded, because the index pipeline and counter are cleared.
  - The top level must reset ColorCalc in the same cycle.

## Configuration
- `COLORSCHED_SKIP_ZERO_EN`:
  - When defined: in ISSUE, a note whose `noteAmplitudeFast` is 0 is not issued (`cc_start_o`=0, in-flight counter unchanged). Buffer[k]=24'h0 is written directly in that cycle, and k still advances one per cycle. The buffer then has two write ports; the direct write and the return write always target different indices.
  - When undefined: every note is issued.
  - Either way, output is identical, because ColorCalc forces rgb=0 for zero amplitude.

## Structure
- Package `colorsched_pkg`:
  - `typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} sched_state_t`.
  - `typedef logic [23:0] rgb_t`.
  - `localparam CC_LAT_DEFAULT = 3`.
- Sub-module `color_frame_buffer`:
  - N×rgb_t register array.
  - Two write ports, with port 1 present only under the macro.
  - One registered read port.

## Test plan
- Reset then N=12 frame, ColorCalc model returning rgb=k+1 for note k, `led_ready_i`=1 → `cc_start_o` high cycles 1–12; `led_valid_o` first at cycle 16; idx 0..11 carry 1..12; `led_last_o` only with idx 11; `busy_o` low at cycle 28.
- `led_ready_i` toggling 1,0,0,1 repeatedly → each index is output exactly once, and `led_rgb_o`/`led_idx_o` hold stable while ready=0.
- `frame_start` at cycle 5 of ISSUE → `frame_drop_o` single pulse; the output stream is unchanged.
- `rst_n` low at cycle 8 of ISSUE, then a new frame → no stale data; all 12 new results are correct.
- Notes 3 and 7 with amplitude 0 → indices 3 and 7 output 24'h0. With the macro, exactly 10 `cc_start_o` pulses; without it, 12.
- Spurious `cc_data_v_i` in IDLE → buffer unchanged; the next frame's results are correct.
